// File: rtl/demux1to4_buf.sv
// ----------------------------------------------------------------------------
// demux1to4_buf
//   Routes one source word to one of four destination lanes. Each lane has a
//   one-entry output buffer with a valid/ready handshake, so a stalled
//   consumer only blocks words aimed at its own lane.
//
// Ports
//   clk            rising-edge system clock
//   rst_n          asynchronous active-low reset
//   in_valid       producer presents a word
//   in_ready       block accepts the word this cycle (combinational)
//   in_data        word to route
//   sel            destination lane (0..3)
//   out_valid[k]   lane k buffer holds a word
//   out_ready[k]   consumer k takes the lane k word this cycle
//   out_data0..3   lane buffer contents
//   accept_count   words accepted since reset, wraps modulo 2^CNT_W
//   busy           any lane holds a word (registered)
// ----------------------------------------------------------------------------
module demux1to4_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] accept_count,
    output logic             busy
);

    localparam int LANES = 4;

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [LANES];
    logic [WIDTH-1:0] data_d [LANES];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             busy_d;
    logic             in_ready_s;
    logic             accept_s;

    // Handshake: only the selected lane decides; a lane draining this cycle
    // frees its slot in time for a same-cycle reload.
    always_comb begin
        in_ready_s = ~valid_q[sel] | out_ready[sel];
        accept_s   = in_valid & in_ready_s;
    end

    // Next-state: drain first, then an accepted word overrides the drain of
    // its own lane so drain+reload keeps the lane valid.
    always_comb begin
        valid_d = valid_q & ~out_ready;
        for (int k = 0; k < LANES; k++) begin
            data_d[k] = data_q[k];
        end
        cnt_d = cnt_q;
        if (accept_s) begin
            valid_d[sel] = 1'b1;
            data_d[sel]  = in_data;
            cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        // busy mirrors the next out_valid so it is a flop, yet equals |out_valid
        busy_d = |valid_d;
    end

    // State registers with asynchronous clear; buffered words are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= {WIDTH{1'b0}};
            end
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= data_d[k];
            end
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = valid_q;
    assign out_data0    = data_q[0];
    assign out_data1    = data_q[1];
    assign out_data2    = data_q[2];
    assign out_data3    = data_q[3];
    assign accept_count = cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// Scoreboard bench for demux1to4_buf: per-lane expected-word queues are filled
// on every accepted word and drained when a consumer takes its lane word.
module tb_demux1to4_buf;

    localparam int WIDTH = 32;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [CW-1:0]    accept_count;
    logic             busy;

    logic [WIDTH-1:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: each lane is a queue of words waiting for its consumer
    logic [WIDTH-1:0] lane_q [4][$];
    int               model_cnt = 0;
    logic [3:0]       exp_valid;
    logic             exp_ready;

    demux1to4_buf #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .accept_count(accept_count), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = r;
    endtask

    // monitor / scoreboard, sampling on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 64'd0);
                check("rst_busy", busy, 64'd0);
                check("rst_count", accept_count, 64'd0);
                check("rst_in_ready", in_ready, 64'd1);
                for (int k = 0; k < 4; k++) lane_q[k].delete();
                model_cnt = 0;
            end else begin
                for (int k = 0; k < 4; k++) exp_valid[k] = (lane_q[k].size() != 0);
                exp_ready = !exp_valid[sel] || out_ready[sel];
                check("in_ready", in_ready, exp_ready);
                check("out_valid", out_valid, exp_valid);
                check("busy", busy, |exp_valid);
                check("accept_count", accept_count, model_cnt);
                for (int k = 0; k < 4; k++) begin
                    if (exp_valid[k]) begin
                        check($sformatf("lane%0d_data", k), od[k], lane_q[k][0]);
                        if (out_ready[k]) void'(lane_q[k].pop_front());
                    end
                end
                if (in_valid && exp_ready) begin
                    lane_q[sel].push_back(in_data);
                    model_cnt = (model_cnt + 1) % (1 << CW);
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [31:0] words [4];
        logic        stall;
        logic        v;
        logic [1:0]  s;
        logic [31:0] d;

        rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; in_data = 32'd0; out_ready = 4'd0;
        #3;
        check("reset_data0", out_data0, 64'd0);
        check("reset_data3", out_data3, 64'd0);
        check("reset_in_ready", in_ready, 64'd1);
        @(posedge clk); #1; rst_n = 1'b1;

        // route one word to each lane
        words[0] = 32'h0000_0000; words[1] = 32'hFFFF_FFFF;
        words[2] = 32'h0000_000F; words[3] = 32'hF000_0000;
        for (int i = 0; i < 4; i++) cyc(1'b1, i[1:0], words[i], 4'b0000);
        cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        @(negedge clk); #1;
        check("route_valid", out_valid, 64'hF);
        for (int i = 0; i < 4; i++) check($sformatf("route_data%0d", i), od[i], words[i]);
        check("route_count", accept_count, 64'd4);
        check("route_busy", busy, 64'd1);

        // backpressure on lane1
        cyc(1'b1, 2'd1, 32'h1234_5678, 4'b0000);
        @(negedge clk); #1;
        check("bp_in_ready", in_ready, 64'd0);
        cyc(1'b1, 2'd1, 32'h1234_5678, 4'b0000);
        @(negedge clk); #1;
        check("bp_hold_data1", out_data1, 64'hFFFF_FFFF);
        check("bp_hold_count", accept_count, 64'd4);
        cyc(1'b1, 2'd1, 32'h1234_5678, 4'b0010);
        @(negedge clk); #1;
        check("bp_release_ready", in_ready, 64'd1);
        cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        @(negedge clk); #1;
        check("bp_new_data1", out_data1, 64'h1234_5678);
        check("bp_new_valid1", out_valid[1], 64'd1);

        // lane2 stalled must not block lane0
        cyc(1'b0, 2'd0, 32'd0, 4'b0001);
        cyc(1'b1, 2'd0, 32'hA5A5_A5A5, 4'b0000);
        @(negedge clk); #1;
        check("nb_in_ready", in_ready, 64'd1);
        cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        @(negedge clk); #1;
        check("nb_data0", out_data0, 64'hA5A5_A5A5);
        check("nb_data2", out_data2, 64'h0000_000F);
        check("nb_valid2", out_valid[2], 64'd1);
        check("nb_count", accept_count, 64'd6);

        // streaming into lane3 with all consumers ready
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 2'd3, i, 4'b1111);
            @(negedge clk); #1;
            check("stream_in_ready", in_ready, 64'd1);
            if (i > 1) check("stream_data3", out_data3, i - 1);
        end
        cyc(1'b0, 2'd0, 32'd0, 4'b1111);
        @(negedge clk); #1;
        check("stream_last", out_data3, 64'd8);
        check("stream_count", accept_count, 64'd14);

        // asynchronous reset with all lanes full
        for (int i = 0; i < 4; i++) cyc(1'b1, i[1:0], $urandom | 32'h1, 4'b0000);
        cyc(1'b0, 2'd0, 32'd0, 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 64'd0);
        check("arst_data0", out_data0, 64'd0);
        check("arst_data1", out_data1, 64'd0);
        check("arst_data2", out_data2, 64'd0);
        check("arst_data3", out_data3, 64'd0);
        check("arst_count", accept_count, 64'd0);
        check("arst_busy", busy, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // counter wrap: 17 accepts from reset
        for (int i = 0; i < 17; i++) cyc(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'b1111);
        cyc(1'b0, 2'd0, 32'd0, 4'b1111);
        @(negedge clk); #1;
        check("wrap_count", accept_count, 64'd1);

        // randomized traffic obeying the producer hold rule
        stall = 1'b0;
        v = 1'b0; s = 2'd0; d = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!stall) begin
                v = ($urandom_range(0, 9) < 7);
                s = 2'($urandom_range(0, 3));
                d = $urandom;
            end
            cyc(v, s, d, 4'($urandom_range(0, 15)));
            @(negedge clk); #1;
            stall = in_valid && !in_ready;
        end
        cyc(1'b0, 2'd0, 32'd0, 4'b1111);
        cyc(1'b0, 2'd0, 32'd0, 4'b1111);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
